// File: rtl/op_request_scheduler.sv
// op_request_scheduler
// Front-end controller for the BCD arithmetic datapath. It synchronises and
// edge-detects four trigger lines and applies a lockout window after every
// accepted edge. Accepted ops are queued in a small FIFO and issued one at a
// time over a valid/ready command interface. A datapath overflow freezes the
// scheduler until the next Reset.
module op_request_scheduler #(
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned QDEPTH         = 4,
    parameter int unsigned GAP_CYCLES     = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [3:0]                 Trigger,
    input  logic                       Overflow,
    output logic                       CmdValid,
    output logic [1:0]                 CmdOp,
    input  logic                       CmdReady,
    output logic [$clog2(QDEPTH):0]    QueueCount,
    output logic                       Dropped,
    output logic                       Locked
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Lowest set bit wins when several triggers rise in the same cycle.
    function automatic logic [1:0] lowest_index(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (v[0]) begin
            r = 2'd0;
        end else if (v[1]) begin
            r = 2'd1;
        end else if (v[2]) begin
            r = 2'd2;
        end else if (v[3]) begin
            r = 2'd3;
        end else begin
            r = 2'd0;
        end
        return r;
    endfunction

    // Registers and their next-state values
    logic [3:0]    trig_sync_q;
    logic [3:0]    trig_prev_q;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          locked_q, locked_d;
    logic [1:0]    mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          dropped_q, dropped_d;
    state_t        state_q, state_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [1:0]    cmd_op_q, cmd_op_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    // Combinational helpers
    logic [3:0]    edge_s;
    logic          accept_s;
    logic [1:0]    req_op_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;

    assign edge_s       = trig_sync_q & ~trig_prev_q;
    assign accept_s     = (edge_s != 4'b0000) && (lock_cnt_q == '0) && !locked_q;
    assign req_op_s     = lowest_index(edge_s);
    assign fifo_full_s  = (count_q == CW'(QDEPTH));
    assign fifo_empty_s = (count_q == '0);
    // Overflow flushes the FIFO, so it overrides both push and pop.
    assign pop_s        = (state_q == ST_ISSUE) && CmdReady && !Overflow;
    assign push_s       = accept_s && !Overflow && (!fifo_full_s || pop_s);
    assign drop_s       = accept_s && !Overflow && fifo_full_s && !pop_s;

    // Two-stage trigger capture used for rising-edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            trig_sync_q <= 4'b0000;
            trig_prev_q <= 4'b0000;
        end else begin
            trig_sync_q <= Trigger;
            trig_prev_q <= trig_sync_q;
        end
    end

    // Lockout counter and sticky overflow lock next-state.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q | Overflow;
        if (accept_s) begin
            lock_cnt_d = LW'(LOCKOUT_CYCLES - 1);
        end else if (lock_cnt_q != '0) begin
            lock_cnt_d = lock_cnt_q - LW'(1);
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // FIFO pointer, occupancy and drop-pulse next-state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = drop_s;
        if (Overflow) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Issue FSM next-state and command outputs; overflow abandons everything.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        gap_cnt_d   = gap_cnt_q;
        if (Overflow) begin
            state_d     = ST_IDLE;
            cmd_valid_d = 1'b0;
            cmd_op_d    = 2'd0;
            gap_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s && !locked_q) begin
                        state_d     = ST_ISSUE;
                        cmd_valid_d = 1'b1;
                        cmd_op_d    = mem_q[rd_ptr_q];
                    end else begin
                        state_d     = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (CmdReady) begin
                        state_d     = ST_GAP;
                        cmd_valid_d = 1'b0;
                        gap_cnt_d   = GW'(GAP_CYCLES - 1);
                    end else begin
                        state_d     = ST_ISSUE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d   = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = 2'd0;
                    gap_cnt_d   = '0;
                end
            endcase
        end
    end

    // FIFO storage; written only on an accepted, non-dropped edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= 2'd0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= req_op_s;
        end
    end

    // State register for lockout, lock, FIFO control and issue FSM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dropped_q   <= 1'b0;
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 2'd0;
            gap_cnt_q   <= '0;
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dropped_q   <= dropped_d;
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign CmdValid   = cmd_valid_q;
    assign CmdOp      = cmd_op_q;
    assign QueueCount = count_q;
    assign Dropped    = dropped_q;
    assign Locked     = locked_q;

endmodule

// File: tb/tb_op_request_scheduler.sv
// Self-checking bench for op_request_scheduler: scenario tasks plus a
// scoreboard of expected op codes consumed at every command handshake.
module tb_op_request_scheduler;

    localparam int unsigned LOCKOUT = 1024;
    localparam int unsigned QD      = 4;
    localparam int unsigned GAP     = 1;

    logic        Clk;
    logic        Reset;
    logic [3:0]  Trigger;
    logic        Overflow;
    logic        CmdValid;
    logic [1:0]  CmdOp;
    logic        CmdReady;
    logic [2:0]  QueueCount;
    logic        Dropped;
    logic        Locked;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;
    int drop_cnt = 0;
    logic [1:0] exp_q [$];
    logic [1:0] exp_op;

    op_request_scheduler #(
        .LOCKOUT_CYCLES (LOCKOUT),
        .QDEPTH         (QD),
        .GAP_CYCLES     (GAP)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Trigger    (Trigger),
        .Overflow   (Overflow),
        .CmdValid   (CmdValid),
        .CmdOp      (CmdOp),
        .CmdReady   (CmdReady),
        .QueueCount (QueueCount),
        .Dropped    (Dropped),
        .Locked     (Locked)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard: a handshake happens at the next posedge; inputs are stable here.
    always @(negedge Clk) begin
        if (Reset === 1'b0 && Overflow === 1'b0 && CmdValid === 1'b1 && CmdReady === 1'b1) begin
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cmd got op=%0d, required no command", CmdOp);
            end else begin
                exp_op = exp_q.pop_front();
                if (CmdOp !== exp_op) begin
                    failures++;
                    $display("FAIL cmd_op got %0d, required %0d", CmdOp, exp_op);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        if (Dropped === 1'b1) drop_cnt++;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [3:0] v);
        Trigger = v;
        tick();
        tick();
        Trigger = 4'b0000;
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        Trigger  = 4'b0000;
        Overflow = 1'b0;
        CmdReady = 1'b0;
        tick();
        tick();
        exp_q.delete();
        Reset    = 1'b0;
        drop_cnt = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Trigger = 4'b1111;
        Overflow = 1'b0;
        CmdReady = 1'b1;
        wait_cycles(3);
        checks++;
        if ({CmdValid, CmdOp, QueueCount, Dropped, Locked} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b op=%0d qc=%0d d=%b l=%b, required all 0",
                     CmdValid, CmdOp, QueueCount, Dropped, Locked);
        end
        do_reset();
    endtask

    task automatic test_single();
        int hs0;
        do_reset();
        CmdReady = 1'b1;
        hs0 = hs_cnt;
        Trigger = 4'b0001;
        exp_q.push_back(2'd0);
        tick();
        checks++;
        if (CmdValid !== 1'b0) begin
            failures++;
            $display("FAIL single_valid_k got %b, required 0", CmdValid);
        end
        tick();
        checks++;
        if (CmdValid !== 1'b0 || QueueCount !== 3'd1) begin
            failures++;
            $display("FAIL single_accept got v=%b qc=%0d, required v=0 qc=1", CmdValid, QueueCount);
        end
        tick();
        checks++;
        if (CmdValid !== 1'b1 || CmdOp !== 2'd0) begin
            failures++;
            $display("FAIL single_issue got v=%b op=%0d, required v=1 op=0", CmdValid, CmdOp);
        end
        wait_cycles(2);
        Trigger = 4'b0000;
        wait_cycles(10);
        checks++;
        if (hs_cnt - hs0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_count got %0d commands, required 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_multi_bit();
        int hs0;
        do_reset();
        CmdReady = 1'b1;
        hs0 = hs_cnt;
        exp_q.push_back(2'd1);
        Trigger = 4'b0110;
        tick();
        tick();
        checks++;
        if (QueueCount !== 3'd1) begin
            failures++;
            $display("FAIL multi_qcount got %0d, required 1", QueueCount);
        end
        Trigger = 4'b0000;
        wait_cycles(10);
        checks++;
        if (hs_cnt - hs0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL multi_count got %0d commands, required 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_lockout();
        int hs0;
        do_reset();
        CmdReady = 1'b1;
        hs0 = hs_cnt;
        exp_q.push_back(2'd0);
        pulse(4'b0001);
        wait_cycles(8);
        pulse(4'b1000);
        wait_cycles(20);
        checks++;
        if (hs_cnt - hs0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL lockout_near got %0d commands, required 1", hs_cnt - hs0);
        end
        do_reset();
        CmdReady = 1'b1;
        hs0 = hs_cnt;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        pulse(4'b0001);
        wait_cycles(1098);
        pulse(4'b1000);
        wait_cycles(20);
        checks++;
        if (hs_cnt - hs0 != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL lockout_far got %0d commands, required 2", hs_cnt - hs0);
        end
    endtask

    task automatic test_fifo_full();
        int hs0;
        int mdl_cnt;
        int low_run;
        int rises;
        logic prev_v;
        logic v;
        logic [1:0] ops [5];
        ops[0] = 2'd0; ops[1] = 2'd1; ops[2] = 2'd2; ops[3] = 2'd3; ops[4] = 2'd0;
        do_reset();
        hs0 = hs_cnt;
        mdl_cnt = 0;
        for (int e = 0; e < 5; e++) begin
            if (mdl_cnt < int'(QD)) begin
                exp_q.push_back(ops[e]);
                mdl_cnt++;
            end
            pulse(4'b0001 << ops[e]);
            wait_cycles(1030);
            if (e == 3) begin
                checks++;
                if (drop_cnt != 0 || QueueCount !== 3'd4) begin
                    failures++;
                    $display("FAIL full_before got drops=%0d qc=%0d, required 0 and 4", drop_cnt, QueueCount);
                end
            end
        end
        checks++;
        if (QueueCount !== 3'(mdl_cnt) || drop_cnt != 1) begin
            failures++;
            $display("FAIL full_after got qc=%0d drops=%0d, required qc=%0d drops=1",
                     QueueCount, drop_cnt, mdl_cnt);
        end
        CmdReady = 1'b1;
        prev_v = CmdValid;
        low_run = 0;
        rises = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            v = CmdValid;
            if (v && !prev_v) begin
                rises++;
                checks++;
                if (low_run != int'(GAP) + 1) begin
                    failures++;
                    $display("FAIL gap_len got %0d idle cycles, required %0d", low_run, GAP + 1);
                end
                low_run = 0;
            end
            if (!v) low_run++;
            prev_v = v;
        end
        checks++;
        if (hs_cnt - hs0 != 4 || rises != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d commands rises=%0d, required 4 and 3", hs_cnt - hs0, rises);
        end
    endtask

    task automatic test_overflow();
        int hs0;
        do_reset();
        for (int e = 0; e < 3; e++) begin
            exp_q.push_back(2'(e));
            pulse(4'b0001 << e);
            wait_cycles(1030);
        end
        checks++;
        if (QueueCount !== 3'd3 || CmdValid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_pre got qc=%0d v=%b, required 3 and 1", QueueCount, CmdValid);
        end
        Overflow = 1'b1;
        tick();
        exp_q.delete();
        checks++;
        if (CmdValid !== 1'b0 || QueueCount !== 3'd0 || Locked !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flush got v=%b qc=%0d l=%b, required 0 0 1", CmdValid, QueueCount, Locked);
        end
        Overflow = 1'b0;
        CmdReady = 1'b1;
        hs0 = hs_cnt;
        wait_cycles(1030);
        pulse(4'b0001);
        wait_cycles(20);
        checks++;
        if (Locked !== 1'b1 || QueueCount !== 3'd0 || CmdValid !== 1'b0 || hs_cnt != hs0) begin
            failures++;
            $display("FAIL ovf_locked got l=%b qc=%0d v=%b cmds=%0d, required 1 0 0 0",
                     Locked, QueueCount, CmdValid, hs_cnt - hs0);
        end
    endtask

    task automatic test_reset_mid_issue();
        int hs0;
        do_reset();
        pulse(4'b0100);
        wait_cycles(3);
        checks++;
        if (CmdValid !== 1'b1 || CmdOp !== 2'd2) begin
            failures++;
            $display("FAIL mid_issue got v=%b op=%0d, required 1 and 2", CmdValid, CmdOp);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if ({CmdValid, CmdOp, QueueCount, Dropped, Locked} !== 8'b0) begin
            failures++;
            $display("FAIL mid_reset got v=%b op=%0d qc=%0d d=%b l=%b, required all 0",
                     CmdValid, CmdOp, QueueCount, Dropped, Locked);
        end
        Reset = 1'b0;
        CmdReady = 1'b1;
        hs0 = hs_cnt;
        wait_cycles(10);
        checks++;
        if (hs_cnt != hs0 || CmdValid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after got %0d commands v=%b, required 0 and 0", hs_cnt - hs0, CmdValid);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        Trigger  = 4'b0000;
        Overflow = 1'b0;
        CmdReady = 1'b0;
        test_reset();
        test_single();
        test_multi_bit();
        test_lockout();
        test_fifo_full();
        test_overflow();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
